pe_stream_feeder: RTL and testbench
===================================

Name: pe_stream_feeder

Overview:
- Upstream driver for one PE_Unit. It accepts packed 3-channel pixels on a valid/ready stream and holds each pixel stable on the PE's Ifmap_in for the PE's 3-phase MAC.
- It also drives Filtr_in and Psum_in, generates the PE's en, and captures the finished Psum_out.
- Captured results leave on a valid/ready result stream.
- Its phase counter mirrors the PE's internal 0→1→2 state, so both blocks stay aligned from a shared reset.

Parameters:
- RES_DEPTH, 2: result FIFO entries (power of two, ≥2).
- PSUM_W, 20: partial-sum width; must match the PE.

Ports:
- clk  in  1  system clock; shared with the PE.
- rst_n  in  1  asynchronous, active-low reset; shared with the PE.
- pix_valid  in  1  upstream pixel valid.
- pix_ready  out  1  feeder can take a pixel.
- pix_data  in  24  {ch0[23:16], ch1[15:8], ch2[7:0]}, unsigned 8-bit each.
- wgt_load  in  1  one-cycle strobe that loads wgt_data.
- wgt_data  in  12  {w0[11:8], w1[7:4], w2[3:0]}.
- wgt_busy  out  1  high while a pixel is in flight; wgt_load is ignored while high.
- pe_en  out  1  to PE en.
- pe_ifmap  out  24  to PE Ifmap_in.
- pe_filtr  out  12  to PE Filtr_in.
- pe_psum  out  PSUM_W  to PE Psum_in.
- pe_psum_ret  in  PSUM_W  from PE Psum_out.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts result.
- res_data  out  PSUM_W  completed dot product (signed).

Behaviour:
- Reset values:
  - phase = 0, hold_valid = 0, pending = 0, FIFO empty.
  - pe_ifmap = 0, pe_filtr = 0, pe_en = 0, pix_ready = 0.
  - res_valid = 0, res_data = 0, pe_psum = 0.
  - A reset mid-pixel discards the in-flight pixel and all FIFO contents. The PE resets on the same rst_n, so the two stay aligned.
- Phase counter:
  - Advances 0→1→2→0 only on edges where pe_en = 1; it holds otherwise.
  - phase 0/1/2 equals the PE's state 0/1/2 at all times.
- Hold register:
  - Loaded from pix_data on pix_valid && pix_ready, which sets hold_valid.
  - Drives pe_ifmap; it stays constant for all three phases.
- pix_ready = !hold_valid || (phase == 2 && pe_en). Back-to-back accepts give one pixel per 3 cycles with no bubble.
- hold_valid clears when phase 2 completes and no new pixel is accepted on that same edge.
- pending:
  - Set on the edge where phase 2 completes; the PE's Psum_out then holds the full sum.
  - Cleared when the capture described below happens.
- Capture:
  - Condition: pending && FIFO not full. It is independent of pe_en.
  - Action: push pe_psum_ret into the FIFO and clear pending.
- pe_en = hold_valid && !(phase == 0 && pending && fifo_full).
  - This stall guarantees Psum_out is never overwritten before capture, because the PE freezes while en = 0.
- Simultaneous events:
  - Capture and a phase-0 advance on the same edge are legal and expected in steady state.
  - A FIFO pop and a push on the same edge when full are allowed; the count is unchanged.
- Latency: a pixel handshake at edge T gives phase 0/1/2 during cycles T..T+3, pending set at T+3, capture at T+4, and res_valid high after T+4 if the FIFO was empty.
- Weights:
  - wgt_load is honoured only when wgt_busy = 0, where wgt_busy = hold_valid || pending.
  - pe_filtr updates on the next edge. A load attempted while busy is dropped, with no error flag.
- Result stream:
  - res_data and res_valid come from the FIFO head; pop on res_valid && res_ready.
  - res_data holds stable while res_valid && !res_ready.
- Arithmetic: none inside the feeder. Results pass through bit-exact as signed PSUM_W values.

Optional Feature:
- Macro PE_FEEDER_BIAS_EN.
- Defined:
  - Adds ports bias_load (in, 1) and bias_data (in, PSUM_W), following the same busy rule as the weights.
  - pe_psum is driven from the bias register, so each result = bias + Σ w·x.
- Undefined: ports absent, and pe_psum is tied to 0.

Decomposition:
- Shared package pe_pkg holds:
  - the PSUM_W, IFMAP_W = 24 and FILTR_W = 12 constants;
  - the phase encoding constants PH0/PH1/PH2 = 0/1/2, which are used by the PE and the feeder alike.
- One sub-module: pe_res_fifo, a synchronous FIFO with depth RES_DEPTH and full/empty flags.

Test Plan (bench instantiates the feeder + PE_Unit; checks cycle counts):
- Load wgt 12'h123, send one pixel 24'h0A0B0C with res_ready = 1 → res_data = 20'h00044 (68), res_valid rises 4 edges after the handshake, and is held for exactly one cycle.
- Wgt 12'hFFF, 4 back-to-back pixels of 24'hFFFFFF → pix_ready pattern 1,0,0 repeating; four results of 11475 (20'h02CD3), 3 cycles apart.
- res_ready = 0 with RES_DEPTH = 2 and 4 pixels → after 2 results, pe_en drops in phase 0; raising res_ready later yields all 4 results in order, with no loss or duplication.
- wgt_load pulsed mid-pixel with 12'h000 → ignored; the current result is still computed with the old weights.
- rst_n asserted during phase 1 → all outputs reach their reset values immediately; after release, a new pixel 24'h010203 with wgt 12'h111 gives result 6.
- PE_FEEDER_BIAS_EN defined, bias −5 (20'hFFFFB), wgt 12'h100, pixel 24'h030000 → result −2 (20'hFFFFE).

Source files
------------

// File: rtl/pe_pkg.sv
// Shared constants for the PE and its stream feeder: datapath widths and the
// three-phase MAC encoding both blocks step through in lockstep.
package pe_pkg;

  localparam int PSUM_W  = 20;
  localparam int IFMAP_W = 24;
  localparam int FILTR_W = 12;

  localparam logic [1:0] PH0 = 2'd0;
  localparam logic [1:0] PH1 = 2'd1;
  localparam logic [1:0] PH2 = 2'd2;

  function automatic logic [1:0] next_phase(input logic [1:0] ph);
    return (ph == PH2) ? PH0 : ph + 2'd1;
  endfunction

endpackage

// File: rtl/pe_res_fifo.sv
// Small synchronous result FIFO with full/empty flags; the head entry is
// visible combinationally so the result stream needs no extra read cycle.
module pe_res_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          wr_en;
  logic          rd_en;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
  assign rd_en  = pop && !empty;
  // A push into a full FIFO is legal only when the same edge frees the head slot.
  assign wr_en  = push && (!full || rd_en);
  assign head   = empty ? '0 : mem_q[rd_idx];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mem_q[gi] <= '0;
        end else if (wr_en && (wr_idx == AW'(gi))) begin
          mem_q[gi] <= push_data;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/pe_stream_feeder.sv
// Stream front end for one PE_Unit: holds each pixel for the 3-phase MAC,
// gates the PE enable and captures results. Optional bias: PE_FEEDER_BIAS_EN.
module pe_stream_feeder
  import pe_pkg::*;
#(
  parameter int RES_DEPTH = 2,
  parameter int PSUM_W    = pe_pkg::PSUM_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pix_valid,
  output logic                pix_ready,
  input  logic [IFMAP_W-1:0]  pix_data,
  input  logic                wgt_load,
  input  logic [FILTR_W-1:0]  wgt_data,
  output logic                wgt_busy,
  output logic                pe_en,
  output logic [IFMAP_W-1:0]  pe_ifmap,
  output logic [FILTR_W-1:0]  pe_filtr,
  output logic [PSUM_W-1:0]   pe_psum,
  input  logic [PSUM_W-1:0]   pe_psum_ret,
`ifdef PE_FEEDER_BIAS_EN
  input  logic                bias_load,
  input  logic [PSUM_W-1:0]   bias_data,
`endif
  output logic                res_valid,
  input  logic                res_ready,
  output logic [PSUM_W-1:0]   res_data
);

  logic [1:0]         phase_q, phase_d;
  logic [IFMAP_W-1:0] hold_q, hold_d;
  logic               hold_valid_q, hold_valid_d;
  logic               pending_q, pending_d;
  logic [FILTR_W-1:0] filtr_q, filtr_d;
  logic               run_q, run_d;

  logic fifo_full;
  logic fifo_empty;
  logic capture;
  logic pix_accept;
  logic ph2_done;
  logic res_pop;

  // Freezing the PE in phase 0 keeps Psum_out intact until the FIFO has room.
  assign pe_en      = hold_valid_q && !((phase_q == PH0) && pending_q && fifo_full);
  assign ph2_done   = pe_en && (phase_q == PH2);
  assign pix_ready  = run_q && (!hold_valid_q || ph2_done);
  assign pix_accept = pix_valid && pix_ready;
  assign capture    = pending_q && !fifo_full;
  assign wgt_busy   = hold_valid_q || pending_q;
  assign res_valid  = !fifo_empty;
  assign res_pop    = res_valid && res_ready;
  assign pe_ifmap   = hold_q;
  assign pe_filtr   = filtr_q;

  always_comb begin
    phase_d      = pe_en ? next_phase(phase_q) : phase_q;
    hold_d       = pix_accept ? pix_data : hold_q;
    hold_valid_d = hold_valid_q;
    pending_d    = pending_q;
    filtr_d      = (wgt_load && !wgt_busy) ? wgt_data : filtr_q;
    run_d        = 1'b1;
    if (pix_accept)    hold_valid_d = 1'b1;
    else if (ph2_done) hold_valid_d = 1'b0;
    if (ph2_done)      pending_d = 1'b1;
    else if (capture)  pending_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q      <= PH0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      pending_q    <= 1'b0;
      filtr_q      <= '0;
      run_q        <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      pending_q    <= pending_d;
      filtr_q      <= filtr_d;
      run_q        <= run_d;
    end
  end

`ifdef PE_FEEDER_BIAS_EN
  logic [PSUM_W-1:0] bias_q, bias_d;

  always_comb begin
    bias_d = (bias_load && !wgt_busy) ? bias_data : bias_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bias_q <= '0;
    else        bias_q <= bias_d;
  end

  assign pe_psum = bias_q;
`else
  assign pe_psum = '0;
`endif

  pe_res_fifo #(
    .DEPTH (RES_DEPTH),
    .W     (PSUM_W)
  ) u_res_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (capture),
    .push_data (pe_psum_ret),
    .pop       (res_pop),
    .head      (res_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_pe_stream_feeder.sv
// Directed bench for pe_stream_feeder driving a behavioural three-phase PE.
// Define PE_FEEDER_BIAS_EN to also exercise the bias path.
module tb_pe_stream_feeder;
  import pe_pkg::*;

  localparam int PW = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic [23:0]   pix_data = '0;
  logic          wgt_load = 1'b0;
  logic [11:0]   wgt_data = '0;
  logic          wgt_busy;
  logic          pe_en;
  logic [23:0]   pe_ifmap;
  logic [11:0]   pe_filtr;
  logic [PW-1:0] pe_psum;
  logic [PW-1:0] pe_psum_ret;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [PW-1:0] res_data;
`ifdef PE_FEEDER_BIAS_EN
  logic          bias_load = 1'b0;
  logic [PW-1:0] bias_data = '0;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  pe_stream_feeder #(.RES_DEPTH(2), .PSUM_W(PW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_data    (pix_data),
    .wgt_load    (wgt_load),
    .wgt_data    (wgt_data),
    .wgt_busy    (wgt_busy),
    .pe_en       (pe_en),
    .pe_ifmap    (pe_ifmap),
    .pe_filtr    (pe_filtr),
    .pe_psum     (pe_psum),
    .pe_psum_ret (pe_psum_ret),
`ifdef PE_FEEDER_BIAS_EN
    .bias_load   (bias_load),
    .bias_data   (bias_data),
`endif
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data)
  );

  // Behavioural PE: one unsigned 8x4 product accumulated per enabled phase.
  logic [1:0]    pe_state;
  logic [PW-1:0] pe_acc;
  assign pe_psum_ret = pe_acc;

  function automatic logic [PW-1:0] mac(input logic [7:0] x, input logic [3:0] w);
    return {12'd0, x} * {16'd0, w};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_state <= PH0;
      pe_acc   <= '0;
    end else if (pe_en) begin
      case (pe_state)
        PH0:     pe_acc <= pe_psum + mac(pe_ifmap[23:16], pe_filtr[11:8]);
        PH1:     pe_acc <= pe_acc + mac(pe_ifmap[15:8], pe_filtr[7:4]);
        default: pe_acc <= pe_acc + mac(pe_ifmap[7:0], pe_filtr[3:0]);
      endcase
      pe_state <= (pe_state == PH2) ? PH0 : pe_state + 2'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total_cnt = total_cnt + 1;
    assert (obs === exp_v) begin
      pass_cnt = pass_cnt + 1;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Returns the number of negedges until res_valid, or -1 on timeout.
  task automatic wait_res(output int n);
    n = 0;
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
    if (!res_valid) n = -1;
  endtask

  initial begin
    int n;
    int acc;
    int got;

    // Reset state
    tick();
    tick();
    chk("rst_pix_ready", 32'(pix_ready), 32'd0);
    chk("rst_pe_en", 32'(pe_en), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_ifmap", 32'(pe_ifmap), 32'd0);
    chk("rst_filtr", 32'(pe_filtr), 32'd0);
    chk("rst_psum", 32'(pe_psum), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single pixel, latency and one-cycle result
    wgt_load = 1'b1; wgt_data = 12'h123; res_ready = 1'b1;
    tick();
    wgt_load = 1'b0;
    chk("t1_filtr", 32'(pe_filtr), 32'h123);
    chk("t1_ready", 32'(pix_ready), 32'd1);
    pix_valid = 1'b1; pix_data = 24'h0A0B0C;
    tick();
    pix_valid = 1'b0;
    chk("t1_ifmap", 32'(pe_ifmap), 32'h0A0B0C);
    chk("t1_en", 32'(pe_en), 32'd1);
    chk("t1_busy", 32'(wgt_busy), 32'd1);
    wait_res(n);
    chk("t1_latency", 32'(n), 32'd4);
    chk("t1_data", 32'(res_data), 32'h00044);
    tick();
    chk("t1_one_cycle", 32'(res_valid), 32'd0);
    chk("t1_idle_busy", 32'(wgt_busy), 32'd0);

    // Back-to-back full-scale pixels
    wgt_load = 1'b1; wgt_data = 12'hFFF;
    tick();
    wgt_load = 1'b0;
    chk("t2_filtr", 32'(pe_filtr), 32'hFFF);
    acc = 0; got = 0;
    for (int i = 0; i < 16; i++) begin
      pix_valid = (acc < 4);
      pix_data  = 24'hFFFFFF;
      if (i < 12) chk($sformatf("t2_ready_%0d", i), 32'(pix_ready), 32'((i % 3) == 0));
      chk($sformatf("t2_rv_%0d", i), 32'(res_valid),
          32'((i >= 5) && (i <= 14) && (((i - 5) % 3) == 0)));
      if (res_valid) begin
        chk($sformatf("t2_data_%0d", got), 32'(res_data), 32'h02CD3);
        got++;
      end
      if (pix_valid && pix_ready) acc++;
      tick();
    end
    pix_valid = 1'b0;
    chk("t2_accepts", 32'(acc), 32'd4);
    chk("t2_results", 32'(got), 32'd4);

    // Backpressure: FIFO fills, PE stalls in phase 0, then drains in order
    wgt_load = 1'b1; wgt_data = 12'h111; res_ready = 1'b0;
    tick();
    wgt_load = 1'b0;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      pix_valid = (acc < 4);
      pix_data  = {8'(acc + 1), 16'h0000};
      if (i == 9)  chk("t3_en_before_stall", 32'(pe_en), 32'd1);
      if (i == 10) chk("t3_en_stall", 32'(pe_en), 32'd0);
      if (pix_valid && pix_ready) acc++;
      tick();
    end
    pix_valid = 1'b0;
    chk("t3_accepts", 32'(acc), 32'd4);
    chk("t3_stall_en", 32'(pe_en), 32'd0);
    chk("t3_stall_ready", 32'(pix_ready), 32'd0);
    chk("t3_stall_rv", 32'(res_valid), 32'd1);
    chk("t3_stall_head", 32'(res_data), 32'd1);
    res_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 30; i++) begin
      if (res_valid) begin
        if (got < 4) chk($sformatf("t3_order_%0d", got), 32'(res_data), 32'(got + 1));
        got++;
      end
      tick();
    end
    chk("t3_count", 32'(got), 32'd4);

    // Weight load while busy is dropped
    pix_valid = 1'b1; pix_data = 24'h050607;
    chk("t4_ready", 32'(pix_ready), 32'd1);
    tick();
    pix_valid = 1'b0;
    tick();
    wgt_load = 1'b1; wgt_data = 12'h000;
    chk("t4_busy", 32'(wgt_busy), 32'd1);
    tick();
    wgt_load = 1'b0;
    wait_res(n);
    chk("t4_data", 32'(res_data), 32'd18);
    chk("t4_filtr_kept", 32'(pe_filtr), 32'h111);
    tick();

    // Reset during phase 1, then recover
    pix_valid = 1'b1; pix_data = 24'h080808;
    tick();
    pix_valid = 1'b0;
    tick();
    chk("t5_pre_en", 32'(pe_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_en", 32'(pe_en), 32'd0);
    chk("t5_ready", 32'(pix_ready), 32'd0);
    chk("t5_ifmap", 32'(pe_ifmap), 32'd0);
    chk("t5_filtr", 32'(pe_filtr), 32'd0);
    chk("t5_rv", 32'(res_valid), 32'd0);
    chk("t5_rd", 32'(res_data), 32'd0);
    chk("t5_busy", 32'(wgt_busy), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_ready_after", 32'(pix_ready), 32'd1);
    wgt_load = 1'b1; wgt_data = 12'h111;
    tick();
    wgt_load = 1'b0;
    pix_valid = 1'b1; pix_data = 24'h010203;
    tick();
    pix_valid = 1'b0;
    wait_res(n);
    chk("t5_latency", 32'(n), 32'd4);
    chk("t5_data", 32'(res_data), 32'd6);
    tick();
    chk("t5_no_stale", 32'(res_valid), 32'd0);

`ifdef PE_FEEDER_BIAS_EN
    // Bias added to the dot product
    bias_load = 1'b1; bias_data = 20'hFFFFB;
    wgt_load  = 1'b1; wgt_data  = 12'h100;
    tick();
    bias_load = 1'b0; wgt_load = 1'b0;
    chk("t6_psum", 32'(pe_psum), 32'hFFFFB);
    pix_valid = 1'b1; pix_data = 24'h030000;
    tick();
    pix_valid = 1'b0;
    wait_res(n);
    chk("t6_data", 32'(res_data), 32'hFFFFE);
    tick();
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
